// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and helpers for the register scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DEF_NREGS  = 32;
  localparam int unsigned DEF_LAT_W  = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t              REG_ZERO     = 5'd0;
  localparam logic [DEF_LAT_W-1:0]   LAT_VARIABLE = '0;

  // x0 is hardwired to zero and never tracked
  function automatic logic is_tracked(input reg_addr_t addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage, writeback and stall-control signals between the pipeline and the scoreboard.
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned LAT_W = DEF_LAT_W
);

  logic             id_valid;
  reg_addr_t        id_rs1;
  reg_addr_t        id_rs2;
  reg_addr_t        id_rd;
  logic             id_reg_write;
  logic [LAT_W-1:0] id_lat;
  logic             flush;
  logic             wb_done;
  reg_addr_t        wb_rd;

  logic             pc_write;
  logic             if_id_write;
  logic             control_mux;
  logic [NREGS-1:0] busy_vec;
  logic             err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_lat, flush, wb_done, wb_rd,
    input  pc_write, if_id_write, control_mux, busy_vec, err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_lat, flush, wb_done, wb_rd,
    output pc_write, if_id_write, control_mux, busy_vec, err
  );

endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// One tracked register: latency countdown plus pending-until-writeback flag.
module reg_scoreboard_sb_entry #(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_cnt,
  input  logic [LAT_W-1:0] lat,
  input  logic             set_pend,
  input  logic             clr_pend,
  output logic             pend,
  output logic             busy_c
);

  logic [LAT_W-1:0] cnt;

  // a new fixed-latency issue overrides the running countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (set_cnt) begin
      cnt <= lat;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (set_pend) begin
      pend <= 1'b1;
    end else if (clr_pend) begin
      pend <= 1'b0;
    end
  end

  assign busy_c = (cnt != '0) | pend;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard beside ID: tracks in-flight destinations and stalls on RAW/WAW hazards.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned LAT_W = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_scoreboard_if.slave  bus
);

  logic [NREGS-1:0] busy_vec_c;
  logic [NREGS-1:0] pend_vec;
  logic             stall_c;
  logic             issue_c;
  logic             lat_fixed_c;
  logic             wb_valid_c;
  logic             err_q;

  assign busy_vec_c[0] = 1'b0;
  assign pend_vec[0]   = 1'b0;

  // hazard check against registered state only, so stall has no added latency
  always_comb begin
    stall_c = 1'b0;
    if (bus.id_valid) begin
      stall_c = busy_vec_c[bus.id_rs1] | busy_vec_c[bus.id_rs2]
              | (bus.id_reg_write & busy_vec_c[bus.id_rd]);
    end
  end

  always_comb begin
    issue_c     = bus.id_valid & ~stall_c & ~bus.flush & bus.id_reg_write
                & is_tracked(bus.id_rd);
    lat_fixed_c = bus.id_lat != LAT_W'(LAT_VARIABLE);
    wb_valid_c  = bus.wb_done & is_tracked(bus.wb_rd);
  end

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    logic hit_id;
    logic hit_wb;

    assign hit_id = issue_c & (bus.id_rd == REG_ADDR_W'(r));
    assign hit_wb = wb_valid_c & (bus.wb_rd == REG_ADDR_W'(r));

    reg_scoreboard_sb_entry #(
      .LAT_W (LAT_W)
    ) u_sb_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_cnt  (hit_id & lat_fixed_c),
      .lat      (bus.id_lat),
      .set_pend (hit_id & ~lat_fixed_c),
      .clr_pend (hit_wb),
      .pend     (pend_vec[r]),
      .busy_c   (busy_vec_c[r])
    );
  end

  // writeback for a register that was never pending is a protocol error; sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (wb_valid_c & ~pend_vec[bus.wb_rd]) begin
      err_q <= 1'b1;
    end
  end

  assign bus.pc_write    = ~stall_c;
  assign bus.if_id_write = ~stall_c;
  assign bus.control_mux = stall_c;
  assign bus.busy_vec    = busy_vec_c;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench: stimulus queues expected outputs, a monitor compares at negedge.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int unsigned NREGS = 32;
  localparam int unsigned LAT_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREGS(NREGS), .LAT_W(LAT_W)) bus ();

  reg_scoreboard #(.NREGS(NREGS), .LAT_W(LAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string            name;
    logic [2:0]       ctrl;   // {pc_write, if_id_write, control_mux}
    logic [NREGS-1:0] busy;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic [LAT_W-1:0] lat,
                       input logic fl, input logic wbd, input logic [4:0] wbrd);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_lat       = lat;
    bus.flush        = fl;
    bus.wb_done      = wbd;
    bus.wb_rd        = wbrd;
  endtask

  task automatic push_exp(input string name, input logic stall,
                          input logic [NREGS-1:0] busy, input logic err);
    exp_t e;
    e.name = name;
    e.ctrl = stall ? 3'b001 : 3'b110;
    e.busy = busy;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // monitor: one queued expectation is consumed per falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if ({bus.pc_write, bus.if_id_write, bus.control_mux} !== e.ctrl ||
            bus.busy_vec !== e.busy || bus.err !== e.err) begin
          errors++;
          $display("FAIL %s: got ctrl=%b busy=%h err=%b, want ctrl=%b busy=%h err=%b",
                   e.name, {bus.pc_write, bus.if_id_write, bus.control_mux},
                   bus.busy_vec, bus.err, e.ctrl, e.busy, e.err);
        end
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    next_cycle();
    push_exp("reset", 0, 32'h0, 0);

    // fixed latency 3 on x5
    next_cycle(); rst_n = 1'b1;
    drive(1, 0, 0, 5, 1, 3, 0, 0, 0);  push_exp("fix_issue",   0, 32'h0,  0);
    next_cycle(); drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    push_exp("fix_stall1",  1, 32'h20, 0);
    next_cycle(); push_exp("fix_stall2",  1, 32'h20, 0);
    next_cycle(); push_exp("fix_stall3",  1, 32'h20, 0);
    next_cycle(); push_exp("fix_release", 0, 32'h0,  0);

    // x0 is never tracked
    next_cycle(); drive(1, 0, 0, 0, 1, 7, 0, 0, 0); push_exp("x0_issue",    0, 32'h0, 0);
    next_cycle(); drive(1, 0, 0, 0, 1, 0, 0, 0, 0); push_exp("x0_consumer", 0, 32'h0, 0);

    // variable latency on x7, released one cycle after wb_done
    next_cycle(); drive(1, 0, 0, 7, 1, 0, 0, 0, 0); push_exp("var_issue", 0, 32'h0, 0);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(1, 0, 7, 0, 0, 0, 0, (i == 9), 7);
      push_exp("var_stall", 1, 32'h80, 0);
    end
    next_cycle(); drive(1, 0, 7, 0, 0, 0, 0, 0, 0); push_exp("var_release", 0, 32'h0, 0);

    // WAW on pending x9, then flush suppresses issue of x10
    next_cycle(); drive(1, 0, 0, 9,  1, 0, 0, 0, 0); push_exp("waw_issue",      0, 32'h0,   0);
    next_cycle(); drive(1, 0, 0, 9,  1, 2, 0, 0, 0); push_exp("waw_stall",      1, 32'h200, 0);
    next_cycle(); drive(1, 9, 0, 10, 1, 2, 1, 0, 0); push_exp("flush_stall",    1, 32'h200, 0);
    next_cycle(); drive(1, 0, 0, 10, 1, 2, 1, 0, 0); push_exp("flush_no_issue", 0, 32'h200, 0);
    next_cycle(); drive(0, 0, 0, 0,  0, 0, 0, 1, 9); push_exp("flush_kept",     0, 32'h200, 0);
    next_cycle(); drive(0, 0, 0, 0,  0, 0, 0, 1, 0); push_exp("wb_clear9",      0, 32'h0,   0);

    // wb to x0 ignored, wb to non-pending x12 sets sticky err
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 12); push_exp("wb_x0_ignored", 0, 32'h0, 0);
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  push_exp("err_set",       0, 32'h0, 1);
    next_cycle(); push_exp("err_sticky", 0, 32'h0, 1);

    // async reset in the middle of a countdown
    next_cycle(); drive(1, 0, 0, 5, 1, 7, 0, 0, 0); push_exp("rst_issue", 0, 32'h0,  1);
    next_cycle(); drive(1, 5, 0, 0, 0, 0, 0, 0, 0); push_exp("rst_count", 1, 32'h20, 1);
    next_cycle(); rst_n = 1'b0; push_exp("rst_mid",   0, 32'h0, 0);
    next_cycle(); rst_n = 1'b1; push_exp("rst_after", 0, 32'h0, 0);

    // minimum fixed latency stalls exactly one cycle
    next_cycle(); drive(1, 0, 0, 3, 1, 1, 0, 0, 0); push_exp("lat1_issue",   0, 32'h0, 0);
    next_cycle(); drive(1, 3, 0, 0, 0, 0, 0, 0, 0); push_exp("lat1_stall",   1, 32'h8, 0);
    next_cycle(); push_exp("lat1_release", 0, 32'h0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
